// File: rtl/mdu_stall_ctrl_if.sv
// Bundle between the E-stage datapath/hazard unit and the multiply/divide
// unit: the request, the forwarded operands, the D-stage class hint and
// everything the MDU hands back (busy, stall request, HI/LO, read data).
interface mdu_stall_ctrl_if;
    logic        op_valid;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_sel;
    logic        D_is_md;
    logic        busy;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] md_rd;

    // Pipeline side: issues requests and consumes results/stall.
    modport master (
        output op_valid, md_op, A, B, rd_sel, D_is_md,
        input  busy, stall_md, HI, LO, md_rd
    );

    // MDU side: accepts requests and produces results/stall.
    modport slave (
        input  op_valid, md_op, A, B, rd_sel, D_is_md,
        output busy, stall_md, HI, LO, md_rd
    );
endinterface

// File: rtl/mdu_stall_ctrl.sv
// Multiply/divide unit for the E stage. Owns HI/LO, runs MULT/MULTU/DIV/DIVU
// as fixed-latency operations whose result is computed at the start edge and
// held in pending registers until the final busy edge, services MTHI/MTLO,
// and generates the stall request for MD-class instructions waiting in D.
module mdu_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    mdu_stall_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      hi_pend;
    logic [31:0]      lo_pend;

    md_op_t           op;
    logic             is_arith;
    logic             busy;
    logic             start;

    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic [31:0]      abs_a;
    logic [31:0]      abs_b;
    logic [31:0]      mag_q;
    logic [31:0]      mag_r;
    logic [31:0]      div_q_s;
    logic [31:0]      div_r_s;
    logic [31:0]      safe_b;
    logic [31:0]      div_q_u;
    logic [31:0]      div_r_u;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    assign op       = md_op_t'(bus.md_op);
    assign is_arith = (op == MD_MULT) || (op == MD_MULTU) ||
                      (op == MD_DIV)  || (op == MD_DIVU);
    assign busy     = (cnt != CNT_ZERO);
    assign start    = bus.op_valid && is_arith && !busy;

    // Arithmetic datapath: both products and both quotients/remainders are
    // formed from the current operands so the selected result can be latched
    // into the pending registers at the start edge. Signed division works on
    // magnitudes and fixes the signs afterwards, which also yields the
    // required 0x80000000 / -1 overflow result without a special case.
    always_comb begin
        prod_s  = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
        prod_u  = {32'd0, bus.A} * {32'd0, bus.B};

        safe_b  = (bus.B == 32'd0) ? 32'd1 : bus.B;
        abs_a   = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
        abs_b   = safe_b[31] ? (~safe_b + 32'd1) : safe_b;
        mag_q   = abs_a / abs_b;
        mag_r   = abs_a % abs_b;
        div_q_s = (bus.A[31] ^ bus.B[31]) ? (~mag_q + 32'd1) : mag_q;
        div_r_s = bus.A[31] ? (~mag_r + 32'd1) : mag_r;
        div_q_u = bus.A / safe_b;
        div_r_u = bus.A % safe_b;

        res_hi  = 32'd0;
        res_lo  = 32'd0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                if (bus.B == 32'd0) begin
                    res_hi = bus.A;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_hi = div_r_s;
                    res_lo = div_q_s;
                end
            end
            MD_DIVU: begin
                if (bus.B == 32'd0) begin
                    res_hi = bus.A;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_hi = div_r_u;
                    res_lo = div_q_u;
                end
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

    // Sequencing: while counting down every request is ignored and the last
    // busy edge commits the pending result; when idle, arithmetic ops load
    // the counter and pending result, and MTHI/MTLO write straight through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= CNT_ZERO;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_pend <= 32'd0;
            lo_pend <= 32'd0;
        end else if (busy) begin
            if (cnt == CNT_ONE) begin
                hi_q <= hi_pend;
                lo_q <= lo_pend;
            end
            cnt <= cnt - CNT_ONE;
        end else if (start) begin
            hi_pend <= res_hi;
            lo_pend <= res_lo;
            cnt     <= ((op == MD_MULT) || (op == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
        end else if (bus.op_valid && (op == MD_MTHI)) begin
            hi_q <= bus.A;
        end else if (bus.op_valid && (op == MD_MTLO)) begin
            lo_q <= bus.A;
        end
    end

    // The stall covers the whole busy window plus the start cycle itself, so
    // an MD instruction right behind a starting operation also waits.
    assign bus.stall_md = bus.D_is_md && (busy || (bus.op_valid && is_arith));
    assign bus.busy     = busy;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.md_rd    = bus.rd_sel ? hi_q : lo_q;

endmodule
